// File: rtl/motion_pkg.sv
// Shared direction codes, FSM states and request helpers for the motion sequencer.
package motion_pkg;

    localparam logic [3:0] DIR_REST  = 4'd0;
    localparam logic [3:0] DIR_FWD   = 4'd1;
    localparam logic [3:0] DIR_BACK  = 4'd2;
    localparam logic [3:0] DIR_TURN3 = 4'd3;
    localparam logic [3:0] DIR_TURN4 = 4'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_DEAD
    } state_e;

    // btn is {R, L, D, U}; the lowest direction code wins.
    function automatic logic [3:0] btn_code(input logic [3:0] btn);
        logic [3:0] code;
        code = DIR_REST;
        if (btn[0]) begin
            code = DIR_FWD;
        end else if (btn[1]) begin
            code = DIR_BACK;
        end else if (btn[2]) begin
            code = DIR_TURN3;
        end else if (btn[3]) begin
            code = DIR_TURN4;
        end
        return code;
    endfunction

    function automatic logic dir_valid(input logic [3:0] dir);
        return (dir >= DIR_FWD) && (dir <= DIR_TURN4);
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for asynchronous level inputs.
module btn_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/motion_sequencer.sv
// Arbitrates estop, buttons and autonomous commands into a dead-timed motor direction.
// Define MOTION_BTN_SYNC_EN to pass buttons and estop through two-flop synchronizers.
module motion_sequencer
    import motion_pkg::*;
#(
    parameter int DEADTIME_CYCLES = 1000,
    parameter int DUR_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btnU,
    input  logic             btnD,
    input  logic             btnL,
    input  logic             btnR,
    input  logic             estop,
    input  logic             auto_valid,
    input  logic [3:0]       auto_cmd,
    input  logic [DUR_W-1:0] auto_dur,
    output logic             auto_ready,
    output logic [3:0]       motiondir,
    output logic             auto_done,
    output logic             auto_abort,
    output logic             auto_err
);

    localparam int CNT_W = (DEADTIME_CYCLES > 1) ? $clog2(DEADTIME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEADTIME_CYCLES - 1);

    if (DEADTIME_CYCLES < 1) begin : g_bad_deadtime
        $error("motion_sequencer: DEADTIME_CYCLES must be at least 1");
    end

    logic [4:0] raw_in, sync_in;
    assign raw_in = {estop, btnR, btnL, btnD, btnU};

`ifdef MOTION_BTN_SYNC_EN
    btn_sync #(
        .WIDTH(5)
    ) u_btn_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (raw_in),
        .q    (sync_in)
    );
`else
    assign sync_in = raw_in;
`endif

    state_e           state_q, state_d;
    logic [3:0]       cur_dir_q, cur_dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       motiondir_q, motiondir_d;
    logic             act_q, act_d;
    logic [3:0]       act_dir_q, act_dir_d;
    logic [DUR_W-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             abort_q, abort_d;

    logic       estop_s;
    logic [3:0] btn_dir;
    logic       override;
    logic       counting;
    logic       expire;
    logic       accept;
    logic       cmd_ok;
    logic [3:0] req;

    assign estop_s  = sync_in[4];
    assign btn_dir  = btn_code(sync_in[3:0]);
    assign override = estop_s || (btn_dir != DIR_REST);

    // Duration only elapses while actually driving the command's direction.
    assign counting = act_q && (state_q == ST_DRIVE)
                    && (cur_dir_q == act_dir_q) && !override;
    assign expire   = counting && (rem_q == DUR_W'(1));

    assign auto_ready = rst_n && !override && !act_q
                      && ((state_q == ST_IDLE) || (state_q == ST_DRIVE));
    assign accept     = auto_valid && auto_ready;
    assign cmd_ok     = dir_valid(auto_cmd) && (auto_dur != '0);

    always_comb begin
        req = DIR_REST;
        if (btn_dir != DIR_REST) begin
            req = btn_dir;
        end else if (act_q && !expire) begin
            req = act_dir_q;
        end
    end

    always_comb begin
        act_d     = act_q;
        act_dir_d = act_dir_q;
        rem_d     = rem_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        abort_d   = 1'b0;
        if (act_q && override) begin
            act_d   = 1'b0;
            abort_d = 1'b1;
        end else if (expire) begin
            act_d  = 1'b0;
            done_d = 1'b1;
        end else if (counting) begin
            rem_d = rem_q - DUR_W'(1);
        end
        if (accept) begin
            if (cmd_ok) begin
                act_d     = 1'b1;
                act_dir_d = auto_cmd;
                rem_d     = auto_dur;
            end else begin
                done_d = 1'b1;
                err_d  = !dir_valid(auto_cmd);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_dir_d   = cur_dir_q;
        cnt_d       = cnt_q;
        motiondir_d = motiondir_q;
        if (estop_s) begin
            state_d     = ST_DEAD;
            cnt_d       = CNT_LOAD;
            motiondir_d = DIR_REST;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    motiondir_d = DIR_REST;
                    if (req != DIR_REST) begin
                        state_d     = ST_DRIVE;
                        cur_dir_d   = req;
                        motiondir_d = req;
                    end
                end
                ST_DRIVE: begin
                    if (req != cur_dir_q) begin
                        state_d     = ST_DEAD;
                        cnt_d       = CNT_LOAD;
                        motiondir_d = DIR_REST;
                    end
                end
                ST_DEAD: begin
                    motiondir_d = DIR_REST;
                    if (cnt_q == '0) begin
                        if (req != DIR_REST) begin
                            state_d     = ST_DRIVE;
                            cur_dir_d   = req;
                            motiondir_d = req;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    motiondir_d = DIR_REST;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cur_dir_q   <= DIR_REST;
            cnt_q       <= '0;
            motiondir_q <= DIR_REST;
            act_q       <= 1'b0;
            act_dir_q   <= DIR_REST;
            rem_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_dir_q   <= cur_dir_d;
            cnt_q       <= cnt_d;
            motiondir_q <= motiondir_d;
            act_q       <= act_d;
            act_dir_q   <= act_dir_d;
            rem_q       <= rem_d;
            done_q      <= done_d;
            err_q       <= err_d;
            abort_q     <= abort_d;
        end
    end

    assign motiondir  = motiondir_q;
    assign auto_done  = done_q;
    assign auto_err   = err_q;
    assign auto_abort = abort_q;

endmodule

// File: tb/tb_motion_sequencer.sv
// Self-checking bench for motion_sequencer: vector table, corner sequences, random vs model.
module tb_motion_sequencer;

    localparam int DT = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          btnU = 1'b0, btnD = 1'b0, btnL = 1'b0, btnR = 1'b0;
    logic          estop = 1'b0;
    logic          auto_valid = 1'b0;
    logic [3:0]    auto_cmd = 4'd0;
    logic [DW-1:0] auto_dur = '0;
    logic          auto_ready, auto_done, auto_abort, auto_err;
    logic [3:0]    motiondir;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    motion_sequencer #(
        .DEADTIME_CYCLES(DT),
        .DUR_W          (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btnU      (btnU),
        .btnD      (btnD),
        .btnL      (btnL),
        .btnR      (btnR),
        .estop     (estop),
        .auto_valid(auto_valid),
        .auto_cmd  (auto_cmd),
        .auto_dur  (auto_dur),
        .auto_ready(auto_ready),
        .motiondir (motiondir),
        .auto_done (auto_done),
        .auto_abort(auto_abort),
        .auto_err  (auto_err)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // b is {R, L, D, U}
    task automatic set_in(input int b, input int es, input int av,
                          input int c, input int d);
        logic [3:0] bb;
        bb = 4'(b);
        btnU = bb[0];
        btnD = bb[1];
        btnL = bb[2];
        btnR = bb[3];
        estop = 1'(es);
        auto_valid = 1'(av);
        auto_cmd = 4'(c);
        auto_dur = DW'(d);
    endtask

    typedef struct {
        int n;
        int b;
        int es;
        int av;
        int c;
        int d;
        int rdy;
        int md;
        int dn;
        int er;
        int ab;
    } vec_t;

    localparam int NV = 28;
    vec_t tbl[NV];

    function automatic vec_t v(int n, int b, int es, int av, int c, int d,
                               int rdy, int md, int dn, int er, int ab);
        vec_t r;
        r.n = n; r.b = b; r.es = es; r.av = av; r.c = c; r.d = d;
        r.rdy = rdy; r.md = md; r.dn = dn; r.er = er; r.ab = ab;
        return r;
    endfunction

    // Behavioural reference: current output, remaining forced-rest cycles,
    // and the pending autonomous command with its remaining drive cycles.
    int m_out, m_rest, m_cmd, m_left;
    int e_done, e_err, e_abort;

    function automatic int m_btn();
        logic [3:0] b;
        b = {btnR, btnL, btnD, btnU};
        for (int i = 0; i < 4; i++) begin
            if (b[i]) return i + 1;
        end
        return 0;
    endfunction

    function automatic int m_ready();
        return (m_rest == 0 && !estop && m_btn() == 0 && m_cmd == 0) ? 1 : 0;
    endfunction

    task automatic m_reset();
        m_out = 0; m_rest = 0; m_cmd = 0; m_left = 0;
        e_done = 0; e_err = 0; e_abort = 0;
    endtask

    task automatic m_step();
        int bd, ovr, rdy, cnt_on, exp_now, areq, req, c, d;
        bd = m_btn();
        ovr = (estop || bd != 0) ? 1 : 0;
        rdy = m_ready();
        cnt_on = (m_cmd != 0 && m_rest == 0 && m_out == m_cmd && !ovr) ? 1 : 0;
        exp_now = (cnt_on && m_left == 1) ? 1 : 0;
        areq = (m_cmd != 0 && !exp_now) ? m_cmd : 0;
        req = (bd != 0) ? bd : areq;
        c = int'(auto_cmd);
        d = int'(auto_dur);
        e_done = 0; e_err = 0; e_abort = 0;
        if (estop) begin
            m_out = 0;
            m_rest = DT;
        end else if (m_rest > 0) begin
            if (m_rest == 1) begin
                m_rest = 0;
                m_out = req;
            end else begin
                m_rest--;
            end
        end else if (m_out == 0) begin
            m_out = req;
        end else if (req != m_out) begin
            m_out = 0;
            m_rest = DT;
        end
        if (m_cmd != 0 && ovr) begin
            m_cmd = 0;
            e_abort = 1;
        end else if (exp_now) begin
            m_cmd = 0;
            e_done = 1;
        end else if (cnt_on) begin
            m_left--;
        end
        if (auto_valid && rdy) begin
            if (c >= 1 && c <= 4 && d != 0) begin
                m_cmd = c;
                m_left = d;
            end else begin
                e_done = 1;
                e_err = (c < 1 || c > 4) ? 1 : 0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ones, ndone, first1, done_k, pulses;
        int hold_b;

        tbl[0]  = v(1, 4'b0000, 0, 0, 0, 0,  1, 0, 0, 0, 0);
        tbl[1]  = v(2, 4'b0001, 0, 0, 0, 0,  0, 1, 0, 0, 0);
        tbl[2]  = v(1, 4'b0011, 0, 1, 4, 3,  0, 1, 0, 0, 0);
        tbl[3]  = v(4, 4'b0010, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        tbl[4]  = v(1, 4'b0010, 0, 0, 0, 0,  0, 2, 0, 0, 0);
        tbl[5]  = v(1, 4'b0000, 0, 0, 0, 0,  1, 0, 0, 0, 0);
        tbl[6]  = v(1, 4'b0000, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        tbl[7]  = v(2, 4'b1100, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        tbl[8]  = v(1, 4'b1100, 0, 0, 0, 0,  0, 3, 0, 0, 0);
        tbl[9]  = v(4, 4'b1000, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        tbl[10] = v(1, 4'b1000, 0, 0, 0, 0,  0, 4, 0, 0, 0);
        tbl[11] = v(1, 4'b0000, 0, 0, 0, 0,  1, 0, 0, 0, 0);
        tbl[12] = v(4, 4'b0000, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        tbl[13] = v(1, 4'b0000, 0, 1, 7, 9,  1, 0, 1, 1, 0);
        tbl[14] = v(1, 4'b0000, 0, 0, 0, 0,  1, 0, 0, 0, 0);
        tbl[15] = v(1, 4'b0000, 0, 1, 2, 0,  1, 0, 1, 0, 0);
        tbl[16] = v(1, 4'b0000, 0, 1, 0, 3,  1, 0, 1, 1, 0);
        tbl[17] = v(1, 4'b0000, 0, 1, 1, 2,  1, 0, 0, 0, 0);
        tbl[18] = v(1, 4'b0000, 0, 0, 0, 0,  0, 1, 0, 0, 0);
        tbl[19] = v(1, 4'b0000, 0, 0, 0, 0,  0, 1, 0, 0, 0);
        tbl[20] = v(1, 4'b0000, 0, 0, 0, 0,  0, 0, 1, 0, 0);
        tbl[21] = v(4, 4'b0000, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        tbl[22] = v(1, 4'b0000, 0, 1, 3, 20, 1, 0, 0, 0, 0);
        tbl[23] = v(1, 4'b0000, 0, 0, 0, 0,  0, 3, 0, 0, 0);
        tbl[24] = v(1, 4'b0000, 1, 0, 0, 0,  0, 0, 0, 0, 1);
        tbl[25] = v(1, 4'b0000, 1, 0, 0, 0,  0, 0, 0, 0, 0);
        tbl[26] = v(4, 4'b0000, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        tbl[27] = v(1, 4'b0000, 0, 0, 0, 0,  1, 0, 0, 0, 0);

        // Reset state, with a valid command offered
        set_in(0, 0, 1, 1, 3);
        #2;
        chk("rst.md", int'(motiondir), 0);
        chk("rst.ready", int'(auto_ready), 0);
        chk("rst.pulses", int'({auto_done, auto_err, auto_abort}), 0);
        #5;
        chk("rst.md_after_edge", int'(motiondir), 0);
        chk("rst.ready_after_edge", int'(auto_ready), 0);
        chk("rst.pulses_after_edge", int'({auto_done, auto_err, auto_abort}), 0);
        set_in(0, 0, 0, 0, 0);
        #5;
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                set_in(tbl[i].b, tbl[i].es, tbl[i].av, tbl[i].c, tbl[i].d);
                #1;
                chk($sformatf("vec%0d.%0d.ready", i, k), int'(auto_ready), tbl[i].rdy);
                @(posedge clk);
                #1;
                chk($sformatf("vec%0d.%0d.md", i, k), int'(motiondir), tbl[i].md);
                chk($sformatf("vec%0d.%0d.done", i, k), int'(auto_done), tbl[i].dn);
                chk($sformatf("vec%0d.%0d.err", i, k), int'(auto_err), tbl[i].er);
                chk($sformatf("vec%0d.%0d.abort", i, k), int'(auto_abort), tbl[i].ab);
            end
        end

        // Five-cycle forward command from IDLE
        set_in(0, 0, 1, 1, 5);
        #1;
        chk("dur5.ready", int'(auto_ready), 1);
        @(posedge clk);
        #1;
        set_in(0, 0, 0, 0, 0);
        ones = 0; ndone = 0; first1 = -1; done_k = -1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (motiondir == 4'd1) begin
                ones++;
                if (first1 < 0) first1 = k;
            end
            if (auto_done) begin
                ndone++;
                done_k = k;
            end
        end
        chk("dur5.fwd_cycles", ones, 5);
        chk("dur5.first_fwd", first1, 0);
        chk("dur5.done_count", ndone, 1);
        chk("dur5.done_cycle", done_k, 5);
        chk("dur5.final_md", int'(motiondir), 0);
        chk("dur5.final_ready", int'(auto_ready), 1);

        // Reset mid-DRIVE with a command active
        set_in(0, 0, 1, 4, 50);
        @(posedge clk);
        #1;
        set_in(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rstmid.driving", int'(motiondir), 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid.md_async", int'(motiondir), 0);
        chk("rstmid.ready", int'(auto_ready), 0);
        pulses = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            pulses += int'(auto_done) + int'(auto_abort) + int'(auto_err);
        end
        rst_n = 1'b1;
        #1;
        chk("rstmid.ready_after", int'(auto_ready), 1);
        @(posedge clk);
        #1;
        pulses += int'(auto_done) + int'(auto_abort) + int'(auto_err);
        chk("rstmid.no_pulses", pulses, 0);
        chk("rstmid.md_idle", int'(motiondir), 0);
        set_in(4'b1000, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("rstmid.first_req", int'(motiondir), 4);

        // Randomized run against the reference model
        set_in(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        m_reset();
        hold_b = 0;
        for (int c = 0; c < 3000; c++) begin
            int r;
            if ($urandom_range(0, 7) == 0) begin
                r = int'($urandom_range(0, 14));
                if (r < 10) hold_b = 0;
                else if (r < 14) hold_b = 1 << (r - 10);
                else hold_b = int'($urandom_range(1, 15));
            end
            if (estop) r = ($urandom_range(0, 3) == 0) ? 0 : 1;
            else r = ($urandom_range(0, 59) == 0) ? 1 : 0;
            set_in(hold_b, r,
                   ($urandom_range(0, 2) == 0) ? 1 : 0,
                   ($urandom_range(0, 9) < 8) ? int'($urandom_range(1, 4))
                                              : int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 10)));
            #1;
            chk("rand.ready", int'(auto_ready), m_ready());
            @(posedge clk);
            m_step();
            #1;
            chk("rand.md", int'(motiondir), m_out);
            chk("rand.done", int'(auto_done), e_done);
            chk("rand.err", int'(auto_err), e_err);
            chk("rand.abort", int'(auto_abort), e_abort);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
